// File: rtl/native_bus_dma_pkg.sv
// Shared types and constants for the native-bus word-copy DMA.
//   state_e      : engine state encoding
//   WSTRB_RD/WR  : byte strobes for read and full-word write transactions
//   WORD_BYTES   : address stride per copied word
package native_bus_dma_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StGapW,
    StWr,
    StGapR,
    StFin
  } state_e;

  localparam logic [3:0]  WSTRB_RD   = 4'h0;
  localparam logic [3:0]  WSTRB_WR   = 4'hF;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // True when either byte address is not on a 32-bit word boundary.
  function automatic logic misaligned(logic [1:0] src_lo, logic [1:0] dst_lo);
    return |(src_lo | dst_lo);
  endfunction

endpackage

// File: rtl/native_bus_dma_if.sv
// Native memory bus (valid/ready) between an initiator and a responder.
//   master : drives mem_valid/instr/addr/wdata/wstrb, receives mem_ready/rdata
//   slave  : the responder view
interface native_bus_dma_if;

  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/native_bus_dma_nb_wait_timer.sv
// Transaction wait timer for a native-bus initiator.
//   clk, resetn : clock, synchronous active-low reset
//   clear       : restart the count (held while no transaction is pending)
//   enable      : count this cycle (request pending, not acknowledged)
//   expired     : this stalled cycle is the TIMEOUT-th one; abandon the transaction
module nb_wait_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Combinational so the initiator can leave on the edge that completes TIMEOUT stalls.
  assign expired = enable && (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CntW'(TIMEOUT))) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/native_bus_dma.sv
// Word-copy DMA initiator on the native memory bus.
//   clk, resetn          : clock, synchronous active-low reset
//   start                : launch request, sampled only when idle
//   src_addr, dst_addr   : word-aligned byte addresses
//   len_words            : words to copy
//   abort                : stop at the next transaction boundary
//   busy, done, err      : status (done is a one-cycle pulse, err is sticky)
//   words_done           : words fully written in the current/last copy
//   bus                  : native bus master port
module native_bus_dma
  import native_bus_dma_pkg::*;
#(
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_done,
  native_bus_dma_if.master bus
);

  state_e           state_q, state_d;
  logic [31:0]      cur_src_q, cur_src_d;
  logic [31:0]      cur_dst_q, cur_dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      buf_q, buf_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] wd_q, wd_d;
  logic             abort_q, abort_d;
  logic             expired;

  // Every transaction is preceded by a non-valid cycle, so clearing on !mem_valid
  // restarts the timer for each one.
  nb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (!bus.mem_valid),
    .enable  (bus.mem_valid && !bus.mem_ready),
    .expired (expired)
  );

  always_comb begin
    state_d   = state_q;
    cur_src_d = cur_src_q;
    cur_dst_d = cur_dst_q;
    len_d     = len_q;
    buf_d     = buf_q;
    err_d     = err_q;
    wd_d      = wd_q;
    abort_d   = abort_q;

    if ((state_q != StIdle) && abort) begin
      abort_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cur_src_d = src_addr;
          cur_dst_d = dst_addr;
          len_d     = len_words;
          err_d     = 1'b0;
          wd_d      = '0;
          abort_d   = 1'b0;
          if (misaligned(src_addr[1:0], dst_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = StFin;
          end else if (len_words == '0) begin
            state_d = StFin;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        if (expired) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else if (bus.mem_ready) begin
          buf_d   = bus.mem_rdata;
          state_d = StGapW;
        end
      end
      StGapW: begin
        // An abort here drops the buffered word without writing it.
        state_d = abort_q ? StFin : StWr;
      end
      StWr: begin
        if (expired) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else if (bus.mem_ready) begin
          cur_src_d = cur_src_q + WORD_BYTES;
          cur_dst_d = cur_dst_q + WORD_BYTES;
          wd_d      = wd_q + LEN_W'(1);
          if ((wd_q + LEN_W'(1) == len_q) || abort_q) begin
            state_d = StFin;
          end else begin
            state_d = StGapR;
          end
        end
      end
      StGapR:  state_d = StRd;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cur_src_q <= '0;
      cur_dst_q <= '0;
      len_q     <= '0;
      buf_q     <= '0;
      err_q     <= 1'b0;
      wd_q      <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_src_q <= cur_src_d;
      cur_dst_q <= cur_dst_d;
      len_q     <= len_d;
      buf_q     <= buf_d;
      err_q     <= err_d;
      wd_q      <= wd_d;
      abort_q   <= abort_d;
    end
  end

  always_comb begin
    bus.mem_valid = (state_q == StRd) || (state_q == StWr);
    bus.mem_instr = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = WSTRB_RD;
    if (state_q == StRd) begin
      bus.mem_addr = cur_src_q;
    end else if (state_q == StWr) begin
      bus.mem_addr  = cur_dst_q;
      bus.mem_wdata = buf_q;
      bus.mem_wstrb = WSTRB_WR;
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StFin);
  assign err        = err_q;
  assign words_done = wd_q;

endmodule

// File: tb/tb_native_bus_dma.sv
module tb_native_bus_dma;

  localparam int unsigned LEN_W   = 16;
  localparam int unsigned TIMEOUT = 16;

  typedef struct {
    string       name;
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          lat;
    int          abort_word;
    bit          mid_start;
    bit          exp_err;
    int          exp_wd;
    int          exp_cyc;
    int          exp_vcyc;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] data;
  } txn_t;

  logic             clk;
  logic             resetn;
  logic             start;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] len_words;
  logic             abort;
  logic             busy;
  logic             done;
  logic             err;
  logic [LEN_W-1:0] words_done;

  native_bus_dma_if bus_if ();

  native_bus_dma #(
    .LEN_W   (LEN_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len_words  (len_words),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .words_done (words_done),
    .bus        (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lat = 1;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   valid_cyc = 0;
  int   low_run = 0;
  bit   seen = 1'b0;
  bit   prev_valid = 1'b0;
  bit   prev_ack = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;
  logic [3:0]  prev_wstrb = '0;
  int   wcnt = 0;
  txn_t exp_q[$];
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, want);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
  endfunction

  function automatic vec_t mk(input string nm, input logic [31:0] s, input logic [31:0] d,
                              input int n, input int l, input int aw, input bit ms,
                              input bit ee, input int ew, input int ec, input int ev);
    vec_t v;
    v.name = nm; v.src = s; v.dst = d; v.len = n; v.lat = l; v.abort_word = aw;
    v.mid_start = ms; v.exp_err = ee; v.exp_wd = ew; v.exp_cyc = ec; v.exp_vcyc = ev;
    return v;
  endfunction

  // Responder and bus monitor, all sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      bus_if.mem_ready = 1'b0;
      wcnt = 0;
      prev_valid = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus_if.mem_valid) begin
        valid_cyc++;
        if (prev_valid && !prev_ack) begin
          chk("stable_addr", bus_if.mem_addr, prev_addr);
          chk("stable_wstrb", 32'(bus_if.mem_wstrb), 32'(prev_wstrb));
          chk("stable_wdata", bus_if.mem_wdata, prev_wdata);
        end
        if (!prev_valid && seen) chk("gap_len", 32'(low_run), 32'd1);
        if (wcnt >= lat) begin
          bus_if.mem_ready = 1'b1;
          bus_if.mem_rdata = pat(bus_if.mem_addr);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_txn: got addr 0x%0h wstrb 0x%0h expected none",
                     bus_if.mem_addr, bus_if.mem_wstrb);
          end else begin
            txn_t e;
            e = exp_q.pop_front();
            chk("txn_addr", bus_if.mem_addr, e.addr);
            chk("txn_wstrb", 32'(bus_if.mem_wstrb), 32'(e.wstrb));
            chk("txn_instr", 32'(bus_if.mem_instr), 32'd0);
            if (e.wstrb == 4'hF) chk("txn_wdata", bus_if.mem_wdata, e.data);
          end
        end else begin
          bus_if.mem_ready = 1'b0;
        end
        wcnt++;
        low_run = 0;
        seen = 1'b1;
      end else begin
        // mem_ready is junk while idle; the DUT must ignore it.
        bus_if.mem_ready = 1'($urandom_range(0, 1));
        bus_if.mem_rdata = $urandom;
        wcnt = 0;
        low_run++;
      end
      prev_valid = bus_if.mem_valid;
      prev_ack   = bus_if.mem_valid && bus_if.mem_ready;
      prev_addr  = bus_if.mem_addr;
      prev_wdata = bus_if.mem_wdata;
      prev_wstrb = bus_if.mem_wstrb;
    end
  end

  task automatic run(input vec_t v);
    int t0;
    logic [31:0] a;
    // Scoreboard: expected bus transactions for this copy.
    if ((v.src[1:0] == 2'b00) && (v.dst[1:0] == 2'b00) && (v.len > 0) && (v.lat < TIMEOUT)) begin
      for (int i = 0; i < v.len; i++) begin
        txn_t t;
        a = v.src + 32'(4 * i);
        t.addr = a; t.wstrb = 4'h0; t.data = '0;
        exp_q.push_back(t);
        if (v.abort_word == i) break;
        t.addr = v.dst + 32'(4 * i); t.wstrb = 4'hF; t.data = pat(a);
        exp_q.push_back(t);
      end
    end
    @(negedge clk); #1;
    abort = 1'b1;  // idle abort must be ignored
    @(negedge clk); #1;
    abort = 1'b0;
    lat = v.lat;
    seen = 1'b0;
    done_cnt = 0;
    valid_cyc = 0;
    src_addr = v.src;
    dst_addr = v.dst;
    len_words = LEN_W'(v.len);
    start = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 2000 && done_cnt == 0; k++) begin
      @(negedge clk); #1;
      start = v.mid_start && (k == 8);
      if (start) begin
        src_addr = 32'h0000_1000;
        dst_addr = 32'h0000_2000;
        len_words = LEN_W'(1);
      end
      abort = (v.abort_word >= 0) && bus_if.mem_valid && (bus_if.mem_wstrb == 4'h0) &&
              (bus_if.mem_addr == v.src + 32'(4 * v.abort_word));
    end
    start = 1'b0;
    abort = 1'b0;
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout: got no done expected done", v.name);
    end
    repeat (4) @(negedge clk);
    #1;
    chk({v.name, "_err"}, 32'(err), 32'(v.exp_err));
    chk({v.name, "_words_done"}, 32'(words_done), 32'(v.exp_wd));
    chk({v.name, "_busy"}, 32'(busy), 32'd0);
    chk({v.name, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({v.name, "_done_cycle"}, 32'(done_cyc - t0), 32'(v.exp_cyc));
    chk({v.name, "_valid_cycles"}, 32'(valid_cyc), 32'(v.exp_vcyc));
    chk({v.name, "_txn_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //       name        src            dst            len lat ab  ms err wd cyc vcyc
    vecs[0] = mk("copy4",  32'h100,      32'h200,      4,  1, -1, 0, 0, 4, 24, 16);
    vecs[1] = mk("len0",   32'h100,      32'h200,      0,  1, -1, 0, 0, 0,  1,  0);
    vecs[2] = mk("src_mis", 32'h102,     32'h200,      3,  1, -1, 0, 1, 0,  1,  0);
    vecs[3] = mk("clr_err", 32'h400,     32'h500,      2,  0, -1, 0, 0, 2,  8,  4);
    vecs[4] = mk("dst_mis", 32'h100,     32'h201,      1,  1, -1, 0, 1, 0,  1,  0);
    vecs[5] = mk("timeout", 32'h100,     32'h200,      2, 1000, -1, 0, 1, 0, 17, 16);
    vecs[6] = mk("abort",  32'h600,      32'h700,      8,  2,  1, 0, 0, 1, 13,  9);
    vecs[7] = mk("wrap",   32'h300,      32'hFFFF_FFF8, 3, 1, -1, 1, 0, 3, 18, 12);

    resetn = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len_words = '0;
    bus_if.mem_ready = 1'b0;
    bus_if.mem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_words_done", 32'(words_done), 32'd0);
    chk("rst_mem_valid", 32'(bus_if.mem_valid), 32'd0);
    chk("rst_mem_addr", bus_if.mem_addr, 32'd0);
    chk("rst_mem_wstrb", 32'(bus_if.mem_wstrb), 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 8; i++) run(vecs[i]);

    // Reset in the middle of a pending read.
    lat = 5;
    seen = 1'b0;
    @(negedge clk); #1;
    src_addr = 32'h800;
    dst_addr = 32'h900;
    len_words = LEN_W'(4);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    chk("midrst_valid_before", 32'(bus_if.mem_valid), 32'd1);
    resetn = 1'b0;
    @(negedge clk); #1;
    chk("midrst_valid", 32'(bus_if.mem_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_words_done", 32'(words_done), 32'd0);
    resetn = 1'b1;
    exp_q.delete();

    // Engine must be fully usable again after the reset.
    run(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/native_bus_dma.md
Name: native_bus_dma

Overview:
- Word-copy DMA engine acting as an *initiator* on the native memory bus (mem_valid/mem_ready handshake), alongside the CPU core.
- Given src, dst and a word count, it alternates one read transaction and one full-word write transaction per word until the count is reached, or until an abort or bus timeout stops it.
- Sits in front of the system bus arbiter and targets the same memory and peripheral map the CPU uses.

Parameters:
- LEN_W, 16, width of the word-count and progress counters.
- TIMEOUT, 64, maximum cycles one transaction may wait for mem_ready before it is abandoned (≥2).

Ports:
- clk  in  1  clock
- resetn  in  1  reset: synchronous, active-low
- start  in  1  launch request; sampled only in IDLE
- src_addr  in  32  source byte address; must be word aligned
- dst_addr  in  32  destination byte address; must be word aligned
- len_words  in  LEN_W  number of 32-bit words to copy
- abort  in  1  stop request; honoured at the next transaction boundary
- busy  out  1  high while not in IDLE
- done  out  1  one-cycle pulse at the end of every accepted start
- err  out  1  sticky error flag (misalignment or timeout); cleared by the next accepted start
- words_done  out  LEN_W  number of words fully written; cleared by an accepted start
- mem_valid  out  1  transaction request
- mem_instr  out  1  tied 0
- mem_addr  out  32  transaction byte address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  4'h0 for a read, 4'hF for a write
- mem_ready  in  1  responder acknowledge
- mem_rdata  in  32  read data; valid in the cycle mem_valid && mem_ready

Behaviour:
- Reset: state IDLE, all outputs 0, internal buffer 0, abort latch clear.
- Bus rules:
  - A transaction completes in the cycle mem_valid && mem_ready.
  - mem_addr, mem_wdata and mem_wstrb are stable while mem_valid is high.
  - mem_valid is driven low for exactly 1 cycle between consecutive transactions.
  - mem_ready is ignored while mem_valid is low.
- States: IDLE, RD, GAP_W, WR, GAP_R, FIN.
- IDLE, start=1 at edge N:
  - Latch src/dst/len; clear err, words_done and the abort latch.
  - If src[1:0]|dst[1:0] != 0: go to FIN with err=1. No bus activity.
  - Else if len==0: go to FIN. No bus activity.
  - Else: go to RD. mem_valid=1 from cycle N+1.
- RD: mem_wstrb=0, mem_addr=cur_src. On ready, latch mem_rdata into the buffer and go to GAP_W.
- GAP_W: mem_valid=0. Go to WR, or to FIN if the abort latch is set (buffered word discarded, not counted).
- WR: mem_wstrb=4'hF, mem_addr=cur_dst, mem_wdata=buffer. On ready:
  - cur_src+=4 and cur_dst+=4, modulo 2^32; wrap past 0xFFFFFFFC to 0x00000000.
  - words_done+=1.
  - Go to FIN if words_done+1==len or the abort latch is set; else go to GAP_R.
- GAP_R: mem_valid=0. Go to RD.
- FIN: done=1 for this one cycle, busy=1. Next state IDLE.
- Timeout: a wait counter clears at each transaction start and counts cycles with mem_valid && !mem_ready. Reaching TIMEOUT sets err=1, drops mem_valid the next cycle and goes to FIN. words_done is not incremented for the abandoned word.
- abort:
  - Any cycle with abort=1 while busy sets the latch.
  - An in-flight transaction always completes or times out first.
  - abort in IDLE is ignored.
  - An abort on the same cycle as completion of the last write has no extra effect.
- start while busy: ignored; it is not queued.
- resetn low in any state: next cycle is IDLE with mem_valid=0, regardless of any outstanding handshake.
- Throughput: with a responder acking 1 cycle after mem_valid, each word costs 6 cycles (2 × (2 valid + 1 gap)).

Decomposition:
- native_bus_dma_pkg: state enum, WSTRB_RD=4'h0 and WSTRB_WR=4'hF constants, WORD_BYTES=4.
- One sub-module, nb_wait_timer: clear/enable inputs, TIMEOUT parameter, expired output. Reusable by other bus initiators.

Test Plan:
- 4-word copy, src 0x100, dst 0x200, responder acks 1 cycle after valid:
  - Exactly 8 transactions, alternating reads and writes.
  - 1-cycle gaps between transactions.
  - dst words equal src words; words_done=4; err=0; single done pulse 24 cycles after start.
- len=0 -> done in the cycle after start; mem_valid never rises; err=0.
- src 0x102, len 3 -> err=1, done pulse, no bus activity. A following aligned start clears err.
- Responder never acks, TIMEOUT=16 -> mem_valid high for exactly 16 cycles, then low; err=1; done pulses; words_done=0.
- 8-word copy, abort pulsed during the 2nd read (3-cycle responder) -> that read completes and no write follows; done pulses; words_done=1; err=0.
- dst 0xFFFFFFF8, len 3 -> writes hit 0xFFFFFFF8, 0xFFFFFFFC, then 0x00000000. A start pulsed mid-copy is ignored: one done pulse only.
